// File: rtl/usb_rx_bit_unstuffer.sv
// USB receive NRZI decoder and bit unstuffer: one decoded bit per shift_enable strobe.
// Optional saturating stuff-error counter enabled by defining USB_RX_STUFF_ERR_CNT_EN.
module usb_rx_bit_unstuffer #(
    parameter int unsigned MAX_ONES = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_line,
    input  logic       shift_enable,
    input  logic       rcving,
    output logic       d_out,
    output logic       bit_valid,
    output logic       stuffing,
    output logic       stuff_err
`ifdef USB_RX_STUFF_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_ONES);

    typedef enum logic [1:0] {IDLE, RECV, STUFF, ERR} state_t;

    state_t     state_q, state_d, state_eff;
    logic       prev_line_q, prev_line_d;
    logic [3:0] ones_cnt_q, ones_cnt_d, ones_inc;
    logic       d_out_q, d_out_d;
    logic       bit_valid_q, bit_valid_d;
    logic       stuffing_q, stuffing_d;
    logic       stuff_err_q, stuff_err_d;
    logic       dec;

    always_comb begin
        dec         = ~(d_line ^ prev_line_q);
        ones_inc    = ones_cnt_q + 4'd1;
        // A strobe arriving with rcving's rising edge is handled as RECV.
        state_eff   = (state_q == IDLE) ? RECV : state_q;
        state_d     = state_q;
        prev_line_d = prev_line_q;
        ones_cnt_d  = ones_cnt_q;
        d_out_d     = d_out_q;
        bit_valid_d = 1'b0;
        stuffing_d  = 1'b0;
        stuff_err_d = 1'b0;

        if (shift_enable)
            prev_line_d = d_line;

        if (!rcving) begin
            // EOP or idle: a truncated run never raises an error.
            state_d    = IDLE;
            ones_cnt_d = '0;
        end else begin
            state_d = state_eff;
            if (shift_enable) begin
                case (state_eff)
                    RECV: begin
                        bit_valid_d = 1'b1;
                        d_out_d     = dec;
                        if (dec) begin
                            ones_cnt_d = ones_inc;
                            if (ones_inc == MAX_CNT)
                                state_d = STUFF;
                        end else begin
                            ones_cnt_d = '0;
                        end
                    end
                    STUFF: begin
                        ones_cnt_d = '0;
                        if (!dec) begin
                            stuffing_d = 1'b1;
                            state_d    = RECV;
                        end else begin
                            stuff_err_d = 1'b1;
                            state_d     = ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            prev_line_q <= 1'b1;
            ones_cnt_q  <= '0;
            d_out_q     <= 1'b0;
            bit_valid_q <= 1'b0;
            stuffing_q  <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_line_q <= prev_line_d;
            ones_cnt_q  <= ones_cnt_d;
            d_out_q     <= d_out_d;
            bit_valid_q <= bit_valid_d;
            stuffing_q  <= stuffing_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    assign d_out     = d_out_q;
    assign bit_valid = bit_valid_q;
    assign stuffing  = stuffing_q;
    assign stuff_err = stuff_err_q;

`ifdef USB_RX_STUFF_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts alongside the registered pulse so both become visible together.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (stuff_err_d && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            err_cnt_q <= '0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_usb_rx_bit_unstuffer.sv
// Directed bench for usb_rx_bit_unstuffer; stimulus is expressed as decoded bits and
// NRZI-encoded here, with expected pulses written out per vector.
module tb_usb_rx_bit_unstuffer;

    logic clk = 1'b0;
    logic n_rst, d_line, shift_enable, rcving;
    logic d_out, bit_valid, stuffing, stuff_err;
`ifdef USB_RX_STUFF_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int   checks = 0;
    int   errors = 0;
    logic line_st;
    logic [19:0] pat;

    usb_rx_bit_unstuffer #(.MAX_ONES(6)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_line       (d_line),
        .shift_enable (shift_enable),
        .rcving       (rcving),
        .d_out        (d_out),
        .bit_valid    (bit_valid),
        .stuffing     (stuffing),
        .stuff_err    (stuff_err)
`ifdef USB_RX_STUFF_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one clk cycle; outputs are then sampled 1 time unit after the edge.
    task automatic step(input logic line, input logic se);
        d_line       = line;
        shift_enable = se;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
    endtask

    task automatic send(input logic b, input logic ev, input logic ed,
                        input logic es, input logic ee, input string tag);
        line_st = b ? line_st : ~line_st;
        step(line_st, 1'b1);
        chk({tag, ".valid"}, 32'(bit_valid), 32'(ev));
        if (ev) chk({tag, ".d"}, 32'(d_out), 32'(ed));
        chk({tag, ".stuffing"}, 32'(stuffing), 32'(es));
        chk({tag, ".stuff_err"}, 32'(stuff_err), 32'(ee));
    endtask

    task automatic idle(input string tag);
        step(line_st, 1'b0);
        chk({tag, ".pulses"}, {29'd0, bit_valid, stuffing, stuff_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; rcving = 1'b0; d_line = 1'b1; shift_enable = 1'b0; line_st = 1'b1;
        #3;
        chk("rst.d_out", 32'(d_out), 32'd0);
        chk("rst.valid", 32'(bit_valid), 32'd0);
        chk("rst.stuffing", 32'(stuffing), 32'd0);
        chk("rst.stuff_err", 32'(stuff_err), 32'd0);
`ifdef USB_RX_STUFF_ERR_CNT_EN
        chk("rst.err_count", 32'(err_count), 32'd0);
`endif
        @(posedge clk); #1;
        n_rst = 1'b1;

        // Idle: strobes are decoded for line tracking only
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle0");
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle1");

        // SYNC: rcving rises with the first strobe
        rcving = 1'b1;
        for (int i = 0; i < 7; i++) send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "sync0");
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "sync_last");
        rcving = 1'b0;
        idle("sync_end");

        // Six ones, stuffed zero, then a one
        rcving = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "run6");
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "stuffbit");
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "post_stuff");
        idle("post_stuff_gap");
        rcving = 1'b0;
        idle("pkt2_end");

        // Six ones then a one where the stuff bit belongs
        rcving = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "err_run");
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "err_bit");
`ifdef USB_RX_STUFF_ERR_CNT_EN
        chk("err_count_one", 32'(err_count), 32'd1);
`endif
        idle("err_gap");
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "err_drop0");
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "err_drop1");
        rcving = 1'b0;
        idle("err_end");
        rcving = 1'b1;
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "after_err");
        rcving = 1'b0;
        idle("pkt3_end");

        // Legal run of six ones truncated by EOP while the stuff bit is due
        rcving = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "eop_run");
        rcving = 1'b0;
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "eop_stuff");
        idle("eop_gap");
        rcving = 1'b1;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "eop_fresh1");
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "eop_fresh0");
        rcving = 1'b0;
        idle("pkt4_end");

        // Reset in the middle of a run of four ones
        rcving = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "prerst");
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst.out", {28'd0, d_out, bit_valid, stuffing, stuff_err}, 32'd0);
        line_st = 1'b1;
        d_line  = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "postrst");
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "postrst_stuff");
        rcving = 1'b0;
        idle("pkt5_end");

        // Back-to-back strobes, 20 bits, longest run of ones is 3
        pat    = 20'b1100_1010_0111_0100_1101;
        rcving = 1'b1;
        for (int i = 0; i < 20; i++)
            send(pat[i], 1'b1, pat[i], 1'b0, 1'b0, $sformatf("b2b%0d", i));
        rcving = 1'b0;
        idle("b2b_end");

`ifdef USB_RX_STUFF_ERR_CNT_EN
        for (int k = 0; k < 300; k++) begin
            rcving = 1'b1;
            for (int i = 0; i < 7; i++) step(line_st, 1'b1);
            rcving = 1'b0;
            step(line_st, 1'b0);
        end
        chk("err_count_sat", 32'(err_count), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
